// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-word pipeline: stage indices and control-word fields.
// Latency: none; this package holds constants only.
// Backpressure: not applicable.
package ctrl_pkg;

  // Stage indices after Decode
  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  // Control-word field bit positions (ALUCTRL occupies ALUCTRL_W bits from ALUCTRL upward)
  localparam int MEMTOREG  = 0;
  localparam int MEMWRITE  = 1;
  localparam int REGWRITE  = 2;
  localparam int MULTORDIV = 3;
  localparam int ALUSRC    = 4;
  localparam int REGDST    = 5;
  localparam int ALUCTRL   = 6;
  localparam int ALUCTRL_W = 3;
  localparam int JAL       = 9;
  localparam int LB        = 10;
  localparam int HLWRITE   = 11;
  localparam int MFHL      = 12;

  // Native control-word width and the bubble word (every enable cleared)
  localparam int CTRL_W = 16;
  localparam logic [CTRL_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Bundle of Decode-side inputs and per-stage control outputs of the control pipeline.
// Latency: none; this interface only groups wires.
// Backpressure: stalls travel as plain level signals (stall_d, flush_e, md_stall).
interface ctrl_pipeline_if #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3
);
  logic [WIDTH-1:0]        ctrl_d;
  logic                    valid_d;
  logic                    stall_d;
  logic                    flush_e;
  logic [STAGES*WIDTH-1:0] ctrl_q;
  logic [STAGES-1:0]       valid_q;
  logic                    md_stall;
  logic                    md_busy;
  logic                    md_done;

  // Hazard unit / decode side drives the inputs
  modport master (
    output ctrl_d, valid_d, stall_d, flush_e,
    input  ctrl_q, valid_q, md_stall, md_busy, md_done
  );

  // Pipeline side
  modport slave (
    input  ctrl_d, valid_d, stall_d, flush_e,
    output ctrl_q, valid_q, md_stall, md_busy, md_done
  );
endinterface

// File: rtl/md_seq.sv
// Mult/div sequencer: counts Execute residency of a mult/div op and requests a front-end stall.
// Latency: outputs are combinational from registered state (counter and Execute stage).
// Backpressure: mdStall holds Execute until the final cycle, where mdDone pulses.
module md_seq #(
  parameter int MD_LATENCY = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic mdE,
  output logic mdStall,
  output logic mdDone
);
  localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MD_LATENCY - 1);

  logic [CNT_W-1:0] cnt;

  // Stall until the op has spent its last cycle in Execute; done marks that last cycle
  assign mdStall = mdE & (cnt != LAST);
  assign mdDone  = mdE & (cnt == LAST);

  // Count while stalling; any other cycle rearms the counter so the next op starts from zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (mdStall) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end
endmodule

// File: rtl/ctrl_pipeline.sv
// Control-word pipeline Decode -> Execute -> Memory -> ... with bubbles and mult/div holding.
// Latency: ctrl_d reaches stage k on the (k+1)th rising edge when not stalled.
// Backpressure: md_stall holds Execute and feeds bubbles into Memory; later stages always drain.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int STAGES     = 3,
  parameter int MD_LATENCY = 8,
  parameter int MD_BIT     = MULTORDIV
) (
  input logic         clk,
  input logic         reset,
  ctrl_pipeline_if.slave bus
);
  localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE);

  logic [WIDTH-1:0] ctrlStage  [STAGES];
  logic             validStage [STAGES];
  logic             mdE;
  logic             mdStall;
  logic             mdDone;

  // A mult/div op is resident when Execute holds a valid word with the multordiv bit set
  assign mdE = validStage[STG_E] & ctrlStage[STG_E][MD_BIT];

  md_seq #(
    .MD_LATENCY(MD_LATENCY)
  ) uMdSeq (
    .clk     (clk),
    .reset   (reset),
    .mdE     (mdE),
    .mdStall (mdStall),
    .mdDone  (mdDone)
  );

  assign bus.md_stall = mdStall;
  assign bus.md_busy  = mdStall;
  assign bus.md_done  = mdDone;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    if (k == STG_E) begin : gExec
      // Execute: mult/div hold beats flush/stall, which beat a normal load from Decode
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ctrlStage[k]  <= BUBBLE_W;
          validStage[k] <= 1'b0;
        end else if (mdStall) begin
          ctrlStage[k]  <= ctrlStage[k];
          validStage[k] <= validStage[k];
        end else if (bus.flush_e || bus.stall_d) begin
          ctrlStage[k]  <= BUBBLE_W;
          validStage[k] <= 1'b0;
        end else begin
          ctrlStage[k]  <= bus.ctrl_d;
          validStage[k] <= bus.valid_d;
        end
      end
    end else if (k == STG_M) begin : gMem
      // Memory: take a bubble while Execute is held, otherwise advance from Execute
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ctrlStage[k]  <= BUBBLE_W;
          validStage[k] <= 1'b0;
        end else if (mdStall) begin
          ctrlStage[k]  <= BUBBLE_W;
          validStage[k] <= 1'b0;
        end else begin
          ctrlStage[k]  <= ctrlStage[k-1];
          validStage[k] <= validStage[k-1];
        end
      end
    end else begin : gLate
      // Writeback and beyond: unconditional shift so older ops drain during mult/div
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ctrlStage[k]  <= BUBBLE_W;
          validStage[k] <= 1'b0;
        end else begin
          ctrlStage[k]  <= ctrlStage[k-1];
          validStage[k] <= validStage[k-1];
        end
      end
    end

    assign bus.ctrl_q[k*WIDTH +: WIDTH] = ctrlStage[k];
    assign bus.valid_q[k]               = validStage[k];
  end
endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: directed vectors, writeback and md_done checked by a monitor.
// Latency: expectations follow the (k+1)th-edge stage timing and the 8-cycle mult/div residency.
// Backpressure: exercises stall_d, flush_e and md_stall holding.
module tb_ctrl_pipeline;
  import ctrl_pkg::*;

  localparam int W   = 16;
  localparam int S   = 3;
  localparam int LAT = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ctrl_pipeline_if #(.WIDTH(W), .STAGES(S)) bus ();

  ctrl_pipeline #(
    .WIDTH(W), .STAGES(S), .MD_LATENCY(LAT), .MD_BIT(MULTORDIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] wbQ   [$];
  logic [W-1:0] doneQ [$];
  logic [W-1:0] monExp;

  function automatic logic [W-1:0] stg(input int k);
    return bus.ctrl_q[k*W +: W];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] c, input logic v, input logic s, input logic f);
    bus.ctrl_d  = c;
    bus.valid_d = v;
    bus.stall_d = s;
    bus.flush_e = f;
  endtask

  // Monitor: every valid writeback word and every md_done pulse must match the next expectation
  always @(negedge clk) begin
    if (reset) begin
      if (bus.valid_q[S-1]) begin
        if (wbQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected actual=%0h required=none", stg(S-1));
        end else begin
          monExp = wbQ.pop_front();
          chk("wb_word", 64'(stg(S-1)), 64'(monExp));
        end
      end
      if (bus.md_done) begin
        if (doneQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL md_done_unexpected actual=%0h required=none", stg(STG_E));
        end else begin
          monExp = doneQ.pop_front();
          chk("md_done_word", 64'(stg(STG_E)), 64'(monExp));
        end
      end
    end
  end

  int done1, done2, lowCnt, pulses;

  initial begin
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    step();
    chk("rst_ctrl_q",   64'(bus.ctrl_q),   64'(0));
    chk("rst_valid_q",  64'(bus.valid_q),  64'(0));
    chk("rst_md_stall", 64'(bus.md_stall), 64'(0));
    chk("rst_md_done",  64'(bus.md_done),  64'(0));
    reset = 1'b1;

    // Plain word walks through all three stages, one per edge
    drive(16'hA5A5, 1'b1, 1'b0, 1'b0);
    wbQ.push_back(16'hA5A5);
    step();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    chk("a5_s0",    64'(stg(0)),       64'(16'hA5A5));
    chk("a5_v1",    64'(bus.valid_q),  64'(3'b001));
    chk("a5_stall", 64'(bus.md_stall), 64'(0));
    step();
    chk("a5_s1", 64'(stg(1)),      64'(16'hA5A5));
    chk("a5_v2", 64'(bus.valid_q), 64'(3'b010));
    step();
    chk("a5_s2", 64'(stg(2)),      64'(16'hA5A5));
    chk("a5_v3", 64'(bus.valid_q), 64'(3'b100));
    step();

    // Decode stall inserts a bubble behind 0x0101; 0x0202 re-presented afterwards
    drive(16'h0101, 1'b1, 1'b0, 1'b0);
    wbQ.push_back(16'h0101);
    step();
    chk("st_s0_first", 64'(stg(0)), 64'(16'h0101));
    drive(16'h0202, 1'b1, 1'b1, 1'b0);
    step();
    chk("st_s0_bubble", 64'(stg(0)),         64'(0));
    chk("st_v0_bubble", 64'(bus.valid_q[0]), 64'(0));
    chk("st_s1",        64'(stg(1)),         64'(16'h0101));
    drive(16'h0202, 1'b1, 1'b0, 1'b0);
    wbQ.push_back(16'h0202);
    step();
    chk("st_s0_second", 64'(stg(0)), 64'(16'h0202));
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    repeat (4) step();

    // Single mult/div op, with flush and stall attempted while it is held
    drive(16'h0008, 1'b1, 1'b0, 1'b0);
    wbQ.push_back(16'h0008);
    doneQ.push_back(16'h0008);
    step();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LAT; i++) begin
      chk("md_s0_hold", 64'(stg(0)),       64'(16'h0008));
      chk("md_stall",   64'(bus.md_stall), 64'(i < LAT - 1));
      chk("md_busy",    64'(bus.md_busy),  64'(i < LAT - 1));
      chk("md_done",    64'(bus.md_done),  64'(i == LAT - 1));
      if (i >= 1) chk("md_s1_bubble", 64'(bus.valid_q[1]), 64'(0));
      if (i == 2) drive(16'h0404, 1'b1, 1'b1, 1'b1);
      if (i == 4) drive(16'h0, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("md_s1_op",    64'(stg(1)),         64'(16'h0008));
    chk("md_v1_op",    64'(bus.valid_q[1]), 64'(1));
    chk("md_after_st", 64'(bus.md_stall),   64'(0));
    repeat (4) step();

    // Back-to-back mult/div ops: second sits in Decode until the first finishes
    drive(16'h0008, 1'b1, 1'b0, 1'b0);
    repeat (2) wbQ.push_back(16'h0008);
    repeat (2) doneQ.push_back(16'h0008);
    step();
    done1  = -1;
    done2  = -1;
    lowCnt = 0;
    for (int t = 0; t < 40; t++) begin
      if (done1 >= 0 && t > done1 && bus.md_done) done2 = t;
      if (done1 < 0 && bus.md_done) done1 = t;
      if (done1 >= 0 && done2 < 0 && !bus.md_stall) lowCnt++;
      if (done1 >= 0 && t == done1 + 1) drive(16'h0, 1'b0, 1'b0, 1'b0);
      if (done2 >= 0) break;
      step();
    end
    chk("b2b_done1",  64'(done1),         64'(LAT - 1));
    chk("b2b_gap",    64'(done2 - done1), 64'(LAT));
    chk("b2b_lowcnt", 64'(lowCnt),        64'(1));
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    repeat (5) step();

    // Reset mid-op at cnt=3: op abandoned, no md_done afterwards
    drive(16'h0008, 1'b1, 1'b0, 1'b0);
    step();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("rm_stall_pre", 64'(bus.md_stall), 64'(1));
    reset = 1'b0;
    #2;
    chk("rm_ctrl_q",  64'(bus.ctrl_q),   64'(0));
    chk("rm_valid_q", 64'(bus.valid_q),  64'(0));
    chk("rm_stall",   64'(bus.md_stall), 64'(0));
    step();
    chk("rm_ctrl_q_edge", 64'(bus.ctrl_q),   64'(0));
    chk("rm_stall_edge",  64'(bus.md_stall), 64'(0));
    reset = 1'b1;
    pulses = 0;
    for (int t = 0; t < 12; t++) begin
      if (bus.md_done) pulses++;
      step();
    end
    chk("rm_no_done", 64'(pulses), 64'(0));

    chk("wbq_empty",   64'(wbQ.size()),   64'(0));
    chk("doneq_empty", 64'(doneQ.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
Parametrised control-word pipeline for the pipelined MIPS core. It carries the decoded control word from Decode through STAGES registered stages (stage 0 = Execute, 1 = Memory, 2 = Writeback, ...), with bubble insertion on stall/flush. It also holds a multi-cycle mult/div op in Execute for MD_LATENCY cycles and raises a stall request to the hazard unit while doing so. It replaces the fixed three-register control pipeline that has no mult/div sequencing.

Parameters:
WIDTH, 16, control-word width in bits
STAGES, 3, number of pipeline stages after Decode (>=2)
MD_LATENCY, 8, total Execute residency of a mult/div op in cycles (>=1)
MD_BIT, 3, index of the multordiv bit within the control word (<WIDTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ctrl_d  in  WIDTH  decoded control word for the instruction in Decode
valid_d  in  1  Decode holds a real instruction
stall_d  in  1  hazard unit stalls F/D; Execute receives a bubble
flush_e  in  1  kill the instruction entering Execute (branch or load-use)
ctrl_q  out  STAGES*WIDTH  stage k control word at bits [k*WIDTH +: WIDTH]
valid_q  out  STAGES  stage k valid bit
md_stall  out  1  request to stall F/D/E while a mult/div op occupies Execute
md_busy  out  1  equal to md_stall
md_done  out  1  one-cycle pulse in the final Execute cycle of a mult/div op; HI/LO write allowed

Behaviour:
- Reset (reset=0, async): all ctrl_q=0, valid_q=0, counter=0, md_stall=0, md_done=0. A mult/div op in flight is abandoned, with no md_done.
- Bubble = ctrl word all zeros, valid 0. All enables are then 0 (regwrite, memwrite, hlwrite).
- md_e = valid_q[0] & ctrl_q[0][MD_BIT].
- Counter cnt, width max(1, clog2(MD_LATENCY)):
  - md_stall = md_e & (cnt != MD_LATENCY-1).
  - md_done = md_e & (cnt == MD_LATENCY-1).
  - While md_stall is high, cnt increments each cycle. Otherwise cnt returns to 0.
- With MD_LATENCY=1, md_stall is never asserted and md_done pulses for the op's single Execute cycle.
- md_stall/md_done are combinational from registered state only. There is no input-to-output combinational path.
- Stage 0 update, in priority order:
  1. md_stall: hold. Both stall_d and flush_e are ignored.
  2. flush_e or stall_d: load bubble.
  3. Otherwise: load {ctrl_d, valid_d}.
- Stage 1 update: load bubble if md_stall, else load stage 0.
- Stage k>=2: always loads stage k-1. Downstream ops drain normally during md_stall.
- A mult/div op in Execute therefore stays exactly MD_LATENCY cycles and reaches stage 1 on the edge after md_done.
- Back-to-back mult/div ops: the second enters Execute the cycle after the first leaves. cnt is 0 on entry, so the full latency repeats.
- Latency when not stalled: ctrl_d reaches stage k on the (k+1)th rising edge.

Decomposition:
- Shared package ctrl_pkg holds:
  - stage index constants (STG_E=0, STG_M=1, STG_W=2);
  - control-word field index localparams (MEMTOREG, MEMWRITE, ALUSRC, REGDST, REGWRITE, ALUCTRL, JAL, LB, MULTORDIV, HLWRITE, MFHL);
  - the BUBBLE constant.
- One sub-module, md_seq: counter plus md_stall/md_done logic. Inputs are md_e and reset.
- Stage registers are a generate loop in ctrl_pipeline.

Test Plan:
- Reset asserted mid mult/div op at cnt=3 -> next cycle all ctrl_q=0, valid_q=0, md_stall=0. After release, with no new op, md_done never pulses.
- ctrl_d=16'hA5A5 (bit3=0), valid_d=1 for one cycle:
  - stage 0 = A5A5 after edge 1, stage 1 after edge 2, stage 2 after edge 3;
  - valid follows the same timing; md_stall stays 0.
- Sequence 0x0101, 0x0202 with stall_d=1 in the second cycle -> stage 0 = 0x0101, then bubble (0, valid 0); stage 1 = 0x0101 one cycle after.
- Op 0x0008 (MD_BIT=3), MD_LATENCY=8:
  - md_stall high for 7 cycles, during which stage 1 receives 7 bubbles;
  - md_done pulses in the 8th cycle;
  - the op appears in stage 1 on the following edge.
- flush_e=1 and stall_d=1 during md_stall -> stage 0 still holds 0x0008 and cnt keeps incrementing. The flush has no effect.
- Two consecutive mult/div ops -> md_done pulses exactly 8 cycles apart; md_stall low for exactly one cycle between them.
